// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with multi-lane write resolution and perf counters
module mem_wb_stage #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_LANES = 2,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [STALL_W-1:0]            stall,
    input  logic                          flush,
    input  logic [NUM_LANES-1:0]          mem_valid,
    input  logic [NUM_LANES*ADDR_W-1:0]   mem_wd,
    input  logic [NUM_LANES-1:0]          mem_wreg,
    input  logic [NUM_LANES*DATA_W-1:0]   mem_wdata,
    input  logic                          mem_whilo,
    input  logic [DATA_W-1:0]             mem_hi,
    input  logic [DATA_W-1:0]             mem_lo,
    input  logic                          mem_llbit_we,
    input  logic                          mem_llbit_value,
    output logic [NUM_LANES-1:0]          wb_valid,
    output logic [NUM_LANES*ADDR_W-1:0]   wb_wd,
    output logic [NUM_LANES-1:0]          wb_wreg,
    output logic [NUM_LANES*DATA_W-1:0]   wb_wdata,
    output logic                          wb_whilo,
    output logic [DATA_W-1:0]             wb_hi,
    output logic [DATA_W-1:0]             wb_lo,
    output logic                          wb_llbit_we,
    output logic                          wb_llbit_value,
    output logic [CNT_W-1:0]              retire_cnt,
    output logic [CNT_W-1:0]              bubble_cnt
);

    logic stall_self, stall_next;
    assign stall_self = stall[STAGE_IDX];
    assign stall_next = stall[STAGE_IDX+1];

    logic [NUM_LANES-1:0]        valid_d, valid_q;
    logic [NUM_LANES*ADDR_W-1:0] wd_d, wd_q;
    logic [NUM_LANES-1:0]        wreg_d, wreg_q;
    logic [NUM_LANES*DATA_W-1:0] wdata_d, wdata_q;
    logic [CNT_W-1:0]            pop_d;
    logic                        whilo_q, llbit_we_q, llbit_value_q;
    logic [DATA_W-1:0]           hi_q, lo_q;
    logic [CNT_W-1:0]            retire_q, bubble_q;

    // Lane resolution: mask invalid lanes, drop r0 writes, and let the highest
    // lane win when several valid lanes write the same register.
    always_comb begin
        valid_d = '0;
        wd_d    = '0;
        wreg_d  = '0;
        wdata_d = '0;
        pop_d   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mem_valid[i]) begin
                valid_d[i]                 = 1'b1;
                wd_d[i*ADDR_W +: ADDR_W]   = mem_wd[i*ADDR_W +: ADDR_W];
                wdata_d[i*DATA_W +: DATA_W] = mem_wdata[i*DATA_W +: DATA_W];
                wreg_d[i] = mem_wreg[i] && (mem_wd[i*ADDR_W +: ADDR_W] != '0);
                pop_d     = pop_d + CNT_W'(1);
                for (int j = i + 1; j < NUM_LANES; j++) begin
                    if (mem_valid[j] && mem_wreg[j] &&
                        (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
                        wreg_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            wd_q          <= '0;
            wreg_q        <= '0;
            wdata_q       <= '0;
            whilo_q       <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            llbit_we_q    <= 1'b0;
            llbit_value_q <= 1'b0;
            retire_q      <= '0;
            bubble_q      <= '0;
        end else if (flush || (stall_self && !stall_next)) begin
            valid_q       <= '0;
            wd_q          <= '0;
            wreg_q        <= '0;
            wdata_q       <= '0;
            whilo_q       <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            llbit_we_q    <= 1'b0;
            llbit_value_q <= 1'b0;
            bubble_q      <= bubble_q + CNT_W'(1);
        end else if (!stall_self) begin
            valid_q       <= valid_d;
            wd_q          <= wd_d;
            wreg_q        <= wreg_d;
            wdata_q       <= wdata_d;
            whilo_q       <= mem_whilo;
            hi_q          <= mem_hi;
            lo_q          <= mem_lo;
            llbit_we_q    <= mem_llbit_we;
            llbit_value_q <= mem_llbit_value;
            retire_q      <= retire_q + pop_d;
        end
    end

    assign wb_valid       = valid_q;
    assign wb_wd          = wd_q;
    assign wb_wreg        = wreg_q;
    assign wb_wdata       = wdata_q;
    assign wb_whilo       = whilo_q;
    assign wb_hi          = hi_q;
    assign wb_lo          = lo_q;
    assign wb_llbit_we    = llbit_we_q;
    assign wb_llbit_value = llbit_value_q;
    assign retire_cnt     = retire_q;
    assign bubble_cnt     = bubble_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with two lanes and 4-bit counters
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NL = 2;
    localparam int SW = 6;
    localparam int SI = 4;
    localparam int CW = 4;

    localparam logic [SW-1:0] ST_RUN    = 6'b000000;
    localparam logic [SW-1:0] ST_BUBBLE = 6'b011111;
    localparam logic [SW-1:0] ST_HOLD   = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [SW-1:0]        stall;
    logic                 flush;
    logic [NL-1:0]        mem_valid;
    logic [NL*AW-1:0]     mem_wd;
    logic [NL-1:0]        mem_wreg;
    logic [NL*DW-1:0]     mem_wdata;
    logic                 mem_whilo;
    logic [DW-1:0]        mem_hi, mem_lo;
    logic                 mem_llbit_we, mem_llbit_value;
    logic [NL-1:0]        wb_valid;
    logic [NL*AW-1:0]     wb_wd;
    logic [NL-1:0]        wb_wreg;
    logic [NL*DW-1:0]     wb_wdata;
    logic                 wb_whilo;
    logic [DW-1:0]        wb_hi, wb_lo;
    logic                 wb_llbit_we, wb_llbit_value;
    logic [CW-1:0]        retire_cnt, bubble_cnt;

    mem_wb_stage #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_LANES(NL),
        .STALL_W(SW), .STAGE_IDX(SI), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we),
        .mem_llbit_value(mem_llbit_value),
        .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
        .wb_wdata(wb_wdata), .wb_whilo(wb_whilo), .wb_hi(wb_hi),
        .wb_lo(wb_lo), .wb_llbit_we(wb_llbit_we),
        .wb_llbit_value(wb_llbit_value),
        .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    typedef struct packed {
        logic [1:0]  valid;
        logic [9:0]  wd;
        logic [1:0]  wreg;
        logic [63:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llv;
        logic [3:0]  ret;
        logic [3:0]  bub;
    } exp_t;

    exp_t model_q;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference behaviour written out lane by lane for the two-lane build.
    function automatic exp_t predict(exp_t cur);
        exp_t n;
        logic s, nx;
        s  = stall[SI];
        nx = stall[SI+1];
        n  = cur;
        if (rst) begin
            n = '0;
        end else if (flush || (s && !nx)) begin
            n     = '0;
            n.ret = cur.ret;
            n.bub = cur.bub + 4'd1;
        end else if (!s) begin
            n.valid = mem_valid;
            n.wd    = '0;
            n.wreg  = '0;
            n.wdata = '0;
            if (mem_valid[0]) begin
                n.wd[4:0]     = mem_wd[4:0];
                n.wdata[31:0] = mem_wdata[31:0];
                n.wreg[0]     = mem_wreg[0] && (mem_wd[4:0] != 5'd0) &&
                                !(mem_valid[1] && mem_wreg[1] && (mem_wd[9:5] == mem_wd[4:0]));
            end
            if (mem_valid[1]) begin
                n.wd[9:5]      = mem_wd[9:5];
                n.wdata[63:32] = mem_wdata[63:32];
                n.wreg[1]      = mem_wreg[1] && (mem_wd[9:5] != 5'd0);
            end
            n.whilo = mem_whilo;
            n.hi    = mem_hi;
            n.lo    = mem_lo;
            n.llwe  = mem_llbit_we;
            n.llv   = mem_llbit_value;
            n.ret   = cur.ret + {3'd0, mem_valid[0]} + {3'd0, mem_valid[1]};
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string name);
        exp_t e;
        e = predict(model_q);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", name);
        end else begin
            e = sb.pop_front();
            chk({name, ".valid"}, 64'(wb_valid), 64'(e.valid));
            chk({name, ".wd"},    64'(wb_wd),    64'(e.wd));
            chk({name, ".wreg"},  64'(wb_wreg),  64'(e.wreg));
            chk({name, ".wdata"}, wb_wdata,      e.wdata);
            chk({name, ".hilo"},  {wb_hi, wb_lo}, {e.hi, e.lo});
            chk({name, ".flags"}, 64'({wb_whilo, wb_llbit_we, wb_llbit_value}),
                                  64'({e.whilo, e.llwe, e.llv}));
            chk({name, ".retire"}, 64'(retire_cnt), 64'(e.ret));
            chk({name, ".bubble"}, 64'(bubble_cnt), 64'(e.bub));
            model_q = e;
        end
    endtask

    task automatic lanes(input logic [1:0] v, input logic [4:0] wd1, input logic [4:0] wd0,
                         input logic [1:0] we, input logic [31:0] d1, input logic [31:0] d0);
        mem_valid = v;
        mem_wd    = {wd1, wd0};
        mem_wreg  = we;
        mem_wdata = {d1, d0};
    endtask

    task automatic side(input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                        input logic llwe, input logic llv);
        mem_whilo       = whilo;
        mem_hi          = hi;
        mem_lo          = lo;
        mem_llbit_we    = llwe;
        mem_llbit_value = llv;
    endtask

    initial begin
        model_q = '0;
        rst   = 1'b1;
        flush = 1'b1;
        stall = ST_HOLD;
        lanes(2'b11, 5'd9, 5'd4, 2'b11, 32'hFFFF_0001, 32'hFFFF_0002);
        side(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1);
        step("reset0");
        step("reset1");

        rst   = 1'b0;
        flush = 1'b0;
        stall = ST_RUN;
        lanes(2'b11, 5'd5, 5'd3, 2'b11, 32'hAAAA_0000, 32'h1234_5678);
        side(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b1);
        step("advance");

        lanes(2'b11, 5'd7, 5'd7, 2'b11, 32'h0000_0077, 32'h0000_0070);
        side(1'b0, 32'h1, 32'h2, 1'b0, 1'b0);
        step("conflict");

        lanes(2'b11, 5'd9, 5'd0, 2'b11, 32'h0000_0099, 32'h0000_0000 | 32'h5A5A);
        step("reg0");

        stall = ST_HOLD;
        lanes(2'b11, 5'd1, 5'd2, 2'b11, 32'hBBBB_BBBB, 32'hCCCC_CCCC);
        side(1'b1, 32'h3, 32'h4, 1'b1, 1'b0);
        step("hold0");
        step("hold1");
        step("hold2");

        stall = ST_BUBBLE;
        step("stall_bubble");

        stall = ST_RUN;
        step("resume");

        flush = 1'b1;
        step("flush_run");
        stall = ST_RUN;
        flush = 1'b0;
        step("refill");
        flush = 1'b1;
        stall = ST_HOLD;
        step("flush_hold");
        flush = 1'b0;
        stall = ST_RUN;

        lanes(2'b01, 5'd6, 5'd8, 2'b11, 32'h6666_6666, 32'h8888_8888);
        step("mask");

        lanes(2'b10, 5'd6, 5'd6, 2'b11, 32'h6666_0000, 32'h0000_6666);
        step("mask_hi_only");

        stall = ST_HOLD;
        rst   = 1'b1;
        step("rst_mid_hold");
        rst   = 1'b0;
        stall = ST_RUN;

        for (int k = 0; k < 16; k++) begin
            lanes(2'b01, 5'd0, 5'(k + 1), 2'b01, 32'h0, 32'(k));
            step($sformatf("wrap%0d", k));
        end

        for (int k = 0; k < 30; k++) begin
            int sel;
            lanes(2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), $urandom, $urandom);
            side(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            sel   = $urandom_range(0, 5);
            stall = (sel == 0) ? ST_HOLD : (sel == 1) ? ST_BUBBLE : ST_RUN;
            flush = ($urandom_range(0, 7) == 0);
            step($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
